// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and a funct3 legality helper.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        logic ok;
        if (write) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the responder (slave).
// Handshake: a request transfers on a rising edge where i_reqValid && o_reqReady;
// a response transfers on a rising edge where o_rspValid && i_rspReady, and the
// response payload is held stable while o_rspValid is high and not yet accepted.
interface dmem_responder_if;
    logic        i_reqValid;
    logic        o_reqReady;
    logic        i_reqWrite;
    logic [31:0] i_addr;
    logic [2:0]  i_funct3;
    logic [31:0] i_wdata;
    logic        o_rspValid;
    logic        i_rspReady;
    logic [31:0] o_rdata;
    logic        o_rspErr;

    modport master (
        output i_reqValid, i_reqWrite, i_addr, i_funct3, i_wdata, i_rspReady,
        input  o_reqReady, o_rspValid, o_rdata, o_rspErr
    );

    modport slave (
        input  i_reqValid, i_reqWrite, i_addr, i_funct3, i_wdata, i_rspReady,
        output o_reqReady, o_rspValid, o_rdata, o_rspErr
    );
endinterface

// File: rtl/dmem_responder_mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-replicated data,
// load extraction with sign/zero extension, and misalign/illegal detection.
module dmem_responder_mem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic        i_write,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_sh,
    output logic [31:0] o_rdata_ext,
    output logic        o_bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign;

    always_comb begin
        byte_sel = i_word[{i_lane, 3'b000} +: 8];
        half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];

        misalign = 1'b0;
        case (i_funct3[1:0])
            2'b01:   misalign = i_lane[0];
            2'b10:   misalign = (i_lane != 2'b00);
            default: misalign = 1'b0;
        endcase
        o_bad = misalign || !f3_legal(i_write, i_funct3);

        // Store data is replicated across lanes; the byte enables pick the live ones.
        case (i_funct3[1:0])
            2'b00: begin
                o_be       = 4'b0001 << i_lane;
                o_wdata_sh = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata_sh = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata_sh = i_wdata;
            end
        endcase

        case (i_funct3)
            F3_LB:   o_rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   o_rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_LW:   o_rdata_ext = i_word;
            F3_LBU:  o_rdata_ext = {24'd0, byte_sel};
            F3_LHU:  o_rdata_ext = {16'd0, half_sel};
            default: o_rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, commits
// the RAM access on the edge entering RESP and holds the response until accepted.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_SIZE_KB = 1,
    parameter int LATENCY     = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    dmem_responder_if.slave  bus,
    output state_t           o_dbg_state
);

    localparam int          MEM_BYTES = MEM_SIZE_KB * 1024;
    localparam int          WORDS     = MEM_BYTES / 4;
    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [3:0]  LAT4      = 4'(LATENCY);

    logic [31:0] mem [WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        a_write;
    logic [31:0] a_addr;
    logic [2:0]  a_funct3;
    logic [31:0] a_wdata;
    logic [AW-3:0] idx;
    logic [31:0] ram_word;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic        lane_bad;
    logic        fault;
    logic        commit;

    // With LATENCY=0 the commit edge is also the accept edge, so the access
    // must see the live request rather than the capture registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            a_write  = bus.i_reqWrite;
            a_addr   = bus.i_addr;
            a_funct3 = bus.i_funct3;
            a_wdata  = bus.i_wdata;
        end else begin
            a_write  = write_q;
            a_addr   = addr_q;
            a_funct3 = funct3_q;
            a_wdata  = wdata_q;
        end
        idx      = a_addr[AW-1:2];
        ram_word = mem[idx];
        fault    = lane_bad || (a_addr >= MEM_LIMIT);
    end

    dmem_responder_mem_lane_align u_align (
        .i_word      (ram_word),
        .i_wdata     (a_wdata),
        .i_lane      (a_addr[1:0]),
        .i_funct3    (a_funct3),
        .i_write     (a_write),
        .o_be        (be),
        .o_wdata_sh  (wdata_sh),
        .o_rdata_ext (rdata_ext),
        .o_bad       (lane_bad)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_reqValid) begin
                    write_d  = bus.i_reqWrite;
                    addr_d   = bus.i_addr;
                    funct3_d = bus.i_funct3;
                    wdata_d  = bus.i_wdata;
                    if (LAT4 == 4'd0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT4;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.i_rspReady) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            err_d   = fault;
            rdata_d = (fault || a_write) ? 32'd0 : rdata_ext;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // RAM is deliberately not reset; a reset coinciding with the commit edge
    // suppresses the write so an interrupted store leaves memory untouched.
    always_ff @(posedge i_clk) begin
        if (commit && !i_reset && a_write && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign bus.o_reqReady = (state_q == ST_IDLE);
    assign bus.o_rspValid = (state_q == ST_RESP);
    assign bus.o_rdata    = rdata_q;
    assign bus.o_rspErr   = err_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=2 and one LATENCY=0
// instance, directed scenarios plus randomized traffic against a byte-array model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit          sel;  // 0 = LATENCY 2 instance, 1 = LATENCY 0 instance
  logic        tb_valid = 1'b0;
  logic        tb_write = 1'b0;
  logic [31:0] tb_addr = 32'd0;
  logic [2:0]  tb_f3 = 3'd0;
  logic [31:0] tb_wdata = 32'd0;
  logic        tb_rsp_ready = 1'b0;

  dmem_responder_if bus2();
  dmem_responder_if bus0();
  state_t st2, st0;

  assign bus2.i_reqValid = tb_valid && !sel;
  assign bus0.i_reqValid = tb_valid && sel;
  assign bus2.i_rspReady = tb_rsp_ready && !sel;
  assign bus0.i_rspReady = tb_rsp_ready && sel;
  assign bus2.i_reqWrite = tb_write;
  assign bus0.i_reqWrite = tb_write;
  assign bus2.i_addr     = tb_addr;
  assign bus0.i_addr     = tb_addr;
  assign bus2.i_funct3   = tb_f3;
  assign bus0.i_funct3   = tb_f3;
  assign bus2.i_wdata    = tb_wdata;
  assign bus0.i_wdata    = tb_wdata;

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? bus0.o_reqReady : bus2.o_reqReady;
  assign cur_valid = sel ? bus0.o_rspValid : bus2.o_rspValid;
  assign cur_rdata = sel ? bus0.o_rdata    : bus2.o_rdata;
  assign cur_err   = sel ? bus0.o_rspErr   : bus2.o_rspErr;

  dmem_responder #(.MEM_SIZE_KB(1), .LATENCY(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2), .o_dbg_state(st2)
  );
  dmem_responder #(.MEM_SIZE_KB(1), .LATENCY(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0), .o_dbg_state(st0)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [2][1024];

  // Reference: access size from funct3, natural alignment, 1 KiB range.
  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int n;
    bit sgn;
    bit ill;
    n = 1; sgn = 0; ill = 0;
    if (w) begin
      case (f3)
        3'd0: n = 1;
        3'd1: n = 2;
        3'd2: n = 4;
        default: ill = 1;
      endcase
    end else begin
      case (f3)
        3'd0: begin n = 1; sgn = 1; end
        3'd1: begin n = 2; sgn = 1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: ill = 1;
      endcase
    end
    er = ill || (a % n != 0) || (a >= 1024);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[s][a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[s][a + i]) << (8*i));
        if (sgn && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endtask

  task automatic send_req(input bit w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    tb_valid = 1'b1; tb_write = w; tb_addr = a; tb_f3 = f3; tb_wdata = wd;
    guard = 0;
    while (!cur_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cur_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: ready=%0b required 1", cur_ready);
    end
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    tb_write = 1'($urandom_range(0, 1));
    tb_addr  = $urandom;
    tb_f3    = 3'($urandom_range(0, 7));
    tb_wdata = $urandom;
  endtask

  task automatic wait_rsp(output int lat, output bit to);
    lat = 1;
    while (!cur_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    to = !cur_valid;
  endtask

  task automatic ack_rsp();
    tb_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    tb_rsp_ready = 1'b0;
  endtask

  task automatic transact(input bit w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat,
                          output logic [31:0] exp_rd, output bit exp_er);
    bit to;
    send_req(w, a, f3, wd);
    wait_rsp(lat, to);
    if (to) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rspValid=%0b required 1 after %0d cycles", cur_valid, lat);
    end
    rd = cur_rdata;
    er = cur_err;
    ack_rsp();
    model(int'(sel), w, a, f3, wd, exp_rd, exp_er);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus2.o_reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b want 1", bus2.o_reqReady); end
    checks++; if (bus2.o_rspValid !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", bus2.o_rspValid); end
    checks++; if (bus2.o_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", bus2.o_rdata); end
    checks++; if (bus2.o_rspErr !== 1'b0) begin errors++; $display("FAIL reset_err2: got %b want 0", bus2.o_rspErr); end
    checks++; if (st2 !== ST_IDLE) begin errors++; $display("FAIL reset_state2: got %0d want %0d", st2, ST_IDLE); end
    checks++; if (bus0.o_reqReady !== 1'b1 || bus0.o_rspValid !== 1'b0) begin
      errors++; $display("FAIL reset_hs0: ready=%b valid=%b want 1/0", bus0.o_reqReady, bus0.o_rspValid);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; bit er, eer; int lat;
    sel = 0;
    transact(1, 32'h10, F3_SW, 32'hDEADBEEF, rd, er, lat, erd, eer);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", er); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
    transact(0, 32'h10, F3_LW, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_data: got %h/%b want deadbeef/0", rd, er);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd, erd; bit er, eer; int lat;
    logic [31:0] la [8];
    logic [2:0]  lf [8];
    logic [31:0] ld [8];
    logic [31:0] le [8];
    bit          lw [8];
    la = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10, 32'h12, 32'h10};
    lf = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_SB, F3_LW, F3_SH, F3_LW};
    lw = '{0, 0, 0, 0, 1, 0, 1, 0};
    ld = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h55, 32'h0, 32'h1234, 32'h0};
    le = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'h0, 32'hDEAD55EF, 32'h0, 32'h123455EF};
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      transact(lw[i], la[i], lf[i], ld[i], rd, er, lat, erd, eer);
      checks++;
      if (rd !== le[i] || er !== 1'b0) begin
        errors++; $display("FAIL lane_%0d: got %h/%b want %h/0", i, rd, er, le[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; bit er, eer; int lat;
    logic [31:0] ea [4];
    logic [2:0]  ef [4];
    bit          ew [4];
    ea = '{32'h12, 32'h11, 32'h400, 32'h10};
    ef = '{F3_LW, F3_SH, F3_LW, 3'b011};
    ew = '{0, 1, 0, 0};
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      transact(ew[i], ea[i], ef[i], 32'hFFFF_FFFF, rd, er, lat, erd, eer);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat != 3) begin
        errors++; $display("FAIL err_%0d: got err=%b rdata=%h lat=%0d want 1/0/3", i, er, rd, lat);
      end
    end
    transact(0, 32'h10, F3_LW, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h123455EF || er !== 1'b0) begin
      errors++; $display("FAIL err_nowrite: got %h/%b want 123455ef/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; logic [31:0] r0, erd; bit e0, eer;
    sel = 0;
    send_req(0, 32'h10, F3_LW, 32'h0);
    wait_rsp(lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: valid=%b want 1", cur_valid); end
    r0 = cur_rdata; e0 = cur_err;
    model(0, 0, 32'h10, F3_LW, 32'h0, erd, eer);
    checks++; if (r0 !== erd || e0 !== eer) begin errors++; $display("FAIL bp_data: got %h/%b want %h/%b", r0, e0, erd, eer); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cur_valid !== 1'b1 || cur_rdata !== r0 || cur_err !== e0 || cur_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                           i, cur_valid, cur_rdata, cur_err, cur_ready, r0, e0);
      end
    end
    ack_rsp();
    checks++; if (cur_ready !== 1'b1 || cur_valid !== 1'b0 || st2 !== ST_IDLE) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", cur_ready, cur_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; bit er, eer; int lat;
    sel = 0;
    transact(1, 32'h20, F3_SW, 32'h0, rd, er, lat, erd, eer);
    send_req(1, 32'h20, F3_SW, 32'hAAAAAAAA);
    checks++; if (st2 !== ST_WAIT) begin errors++; $display("FAIL rst_wait_state: got %0d want %0d", st2, ST_WAIT); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (cur_valid !== 1'b0 || cur_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait_hs: valid=%b ready=%b want 0/1", cur_valid, cur_ready);
    end
    transact(0, 32'h20, F3_LW, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL rst_wait_ram: got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, erd; bit er, eer; int lat; bit to;
    sel = 1;
    transact(1, 32'h40, F3_SW, 32'hCAFEF00D, rd, er, lat, erd, eer);
    checks++; if (lat != 1 || er !== 1'b0) begin errors++; $display("FAIL l0_sw: lat=%0d err=%b want 1/0", lat, er); end
    transact(0, 32'h42, F3_LHU, 32'h0, rd, er, lat, erd, eer);
    checks++; if (lat != 1 || rd !== 32'h0000CAFE) begin errors++; $display("FAIL l0_lhu: lat=%0d rdata=%h want 1/0000cafe", lat, rd); end
    send_req(0, 32'h40, F3_LW, 32'h0);
    wait_rsp(lat, to);
    checks++; if (lat != 1 || to) begin errors++; $display("FAIL l0_rst_lat: lat=%0d want 1", lat); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (cur_valid !== 1'b0 || cur_ready !== 1'b1 || st0 !== ST_IDLE) begin
      errors++; $display("FAIL l0_rst_drop: valid=%b ready=%b want 0/1", cur_valid, cur_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a; bit er, eer, w; int lat; logic [2:0] f3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 17; i++) begin
        a = (i == 16) ? 32'h3FC : 32'(i * 4);
        transact(1, a, F3_SW, 32'h0, rd, er, lat, erd, eer);
      end
    end
    for (int i = 0; i < 80; i++) begin
      sel = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'h3FC + 32'($urandom_range(0, 3));
        1:       a = 32'h400 + 32'($urandom_range(0, 7));
        2:       a = 32'hFFFF_FFF0;
        default: a = 32'($urandom_range(0, 63));
      endcase
      transact(w, a, f3, $urandom, rd, er, lat, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat != (sel ? 1 : 3)) begin
        errors++; $display("FAIL rand_%0d: sel=%0d w=%0b a=%h f3=%0d got %h/%b lat=%0d want %h/%b lat=%0d",
                           i, sel, w, a, f3, rd, er, lat, erd, eer, sel ? 1 : 3);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = 8'h00;
    sel = 0;
    test_reset();
    test_store_load();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
